// File: rtl/softmax_max_issue_ctrl_pkg.sv
// Shared constants for the softmax max/issue controller: state codes,
// lane count and beat-count derivation.
package softmax_max_issue_ctrl_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_ISSUE    = 3'd2;
    localparam logic [2:0] ST_WAIT_ACK = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    localparam int unsigned LANES = 4;

    function automatic int unsigned num_beats(input int unsigned n);
        return (n + LANES - 1) / LANES;
    endfunction

endpackage

// File: rtl/softmax_max_issue_ctrl_max2_cmp.sv
// Combinational "a strictly greater than b" for either two's-complement
// fixed point or sign/magnitude float (+0 == -0, no NaN/Inf handling).
module max2_cmp #(
    parameter int ARITH_TYPE = 0,
    parameter int DATA_WIDTH = 32,
    parameter int E          = 8,
    parameter int M          = 23
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  a_gt_b
);

    generate
        if (ARITH_TYPE == 1) begin : g_fix
            assign a_gt_b = $signed(a) > $signed(b);
        end else begin : g_flt
            logic         w_sa;
            logic         w_sb;
            logic [E+M-1:0] w_ma;
            logic [E+M-1:0] w_mb;

            assign w_sa = a[E+M];
            assign w_sb = b[E+M];
            assign w_ma = a[E+M-1:0];
            assign w_mb = b[E+M-1:0];

            // Negative magnitudes order in reverse; two zeros of any sign tie.
            always_comb begin
                a_gt_b = 1'b0;
                if (w_ma == '0 && w_mb == '0)
                    a_gt_b = 1'b0;
                else if (w_sa != w_sb)
                    a_gt_b = w_sb;
                else if (!w_sa)
                    a_gt_b = w_ma > w_mb;
                else
                    a_gt_b = w_ma < w_mb;
            end
        end
    endgenerate

endmodule

// File: rtl/softmax_max_issue_ctrl.sv
// Buffers a logit vector in 4-lane beats while tracking its maximum, then
// replays it group by group to the exp-input subtractor with ack pacing.
module softmax_max_issue_ctrl
    import softmax_max_issue_ctrl_pkg::*;
#(
    parameter int ARITH_TYPE = 0,
    parameter int DATA_WIDTH = 32,
    parameter int E          = 8,
    parameter int M          = 23,
    parameter int NUM_ELEMS  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_lane1,
    input  logic [DATA_WIDTH-1:0] in_lane2,
    input  logic [DATA_WIDTH-1:0] in_lane3,
    input  logic [DATA_WIDTH-1:0] in_lane4,
    input  logic                  start_exp,
    output logic                  softmax_enable,
    output logic [DATA_WIDTH-1:0] max_input,
    output logic [DATA_WIDTH-1:0] in1,
    output logic [DATA_WIDTH-1:0] in2,
    output logic [DATA_WIDTH-1:0] in3,
    output logic [DATA_WIDTH-1:0] in4,
    output logic [3:0]            lane_mask,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned NUM_BEATS  = num_beats(NUM_ELEMS);
    localparam int unsigned BW         = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int unsigned LAST_LANES = NUM_ELEMS - LANES * (NUM_BEATS - 1);
    localparam logic [BW-1:0] LAST_IDX = BW'(NUM_BEATS - 1);

    logic [2:0]                          r_state;
    logic [BW-1:0]                       r_beat_cnt;
    logic [BW-1:0]                       r_grp_cnt;
    logic [DATA_WIDTH-1:0]               r_run_max;
    logic [DATA_WIDTH-1:0]               r_max_input;
    logic [LANES-1:0][DATA_WIDTH-1:0]    r_lanes;
    logic [LANES-1:0]                    r_mask;
    logic [LANES-1:0][DATA_WIDTH-1:0]    r_buf [NUM_BEATS];

    logic [LANES-1:0][DATA_WIDTH-1:0]    w_beat;
    logic [LANES-1:0]                    w_beat_vld;
    logic                                w_gt0, w_gt1, w_gt2, w_gt3;
    logic [DATA_WIDTH-1:0]               w_best0, w_best1, w_best2, w_best3;
    logic                                w_from_load;
    logic [BW-1:0]                       w_issue_grp;
    logic [DATA_WIDTH-1:0]               w_issue_max;
    logic [LANES-1:0][DATA_WIDTH-1:0]    w_src;
    logic [LANES-1:0][DATA_WIDTH-1:0]    w_issue_lanes;
    logic [LANES-1:0]                    w_issue_mask;

    function automatic logic lane_valid(input logic [BW-1:0] idx, input int unsigned k);
        return (idx != LAST_IDX) || (k < LAST_LANES);
    endfunction

    assign w_beat = {in_lane4, in_lane3, in_lane2, in_lane1};

    // Chain starts from the running max; lane 0 of beat 0 seeds it unconditionally.
    max2_cmp #(.ARITH_TYPE(ARITH_TYPE), .DATA_WIDTH(DATA_WIDTH), .E(E), .M(M))
        u_cmp0 (.a(w_beat[0]), .b(r_run_max), .a_gt_b(w_gt0));
    max2_cmp #(.ARITH_TYPE(ARITH_TYPE), .DATA_WIDTH(DATA_WIDTH), .E(E), .M(M))
        u_cmp1 (.a(w_beat[1]), .b(w_best0), .a_gt_b(w_gt1));
    max2_cmp #(.ARITH_TYPE(ARITH_TYPE), .DATA_WIDTH(DATA_WIDTH), .E(E), .M(M))
        u_cmp2 (.a(w_beat[2]), .b(w_best1), .a_gt_b(w_gt2));
    max2_cmp #(.ARITH_TYPE(ARITH_TYPE), .DATA_WIDTH(DATA_WIDTH), .E(E), .M(M))
        u_cmp3 (.a(w_beat[3]), .b(w_best2), .a_gt_b(w_gt3));

    assign w_best0 = ((r_beat_cnt == '0) || w_gt0) ? w_beat[0] : r_run_max;
    assign w_best1 = (w_beat_vld[1] && w_gt1) ? w_beat[1] : w_best0;
    assign w_best2 = (w_beat_vld[2] && w_gt2) ? w_beat[2] : w_best1;
    assign w_best3 = (w_beat_vld[3] && w_gt3) ? w_beat[3] : w_best2;

    // Next group to present: group 0 straight out of LOAD, else grp_cnt+1.
    always_comb begin
        w_beat_vld    = '0;
        w_issue_mask  = '0;
        w_issue_lanes = '0;
        w_from_load   = (r_state == ST_LOAD);
        w_issue_grp   = w_from_load ? '0 : r_grp_cnt + 1'b1;
        w_issue_max   = w_from_load ? w_best3 : r_max_input;
        w_src         = (w_from_load && NUM_BEATS == 1) ? w_beat : r_buf[w_issue_grp];
        for (int unsigned k = 0; k < LANES; k++) begin
            w_beat_vld[k]    = lane_valid(r_beat_cnt, k);
            w_issue_mask[k]  = lane_valid(w_issue_grp, k);
            w_issue_lanes[k] = w_issue_mask[k] ? w_src[k] : w_issue_max;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_LOAD && in_valid)
            r_buf[r_beat_cnt] <= w_beat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_beat_cnt  <= '0;
            r_grp_cnt   <= '0;
            r_run_max   <= '0;
            r_max_input <= '0;
            r_lanes     <= '0;
            r_mask      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_LOAD;
                        r_beat_cnt <= '0;
                        r_run_max  <= '0;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        r_run_max <= w_best3;
                        if (r_beat_cnt == LAST_IDX) begin
                            r_state     <= ST_ISSUE;
                            r_grp_cnt   <= '0;
                            r_max_input <= w_best3;
                            r_lanes     <= w_issue_lanes;
                            r_mask      <= w_issue_mask;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                ST_ISSUE: r_state <= ST_WAIT_ACK;
                ST_WAIT_ACK: begin
                    if (start_exp) begin
                        if (r_grp_cnt == LAST_IDX) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state   <= ST_ISSUE;
                            r_grp_cnt <= w_issue_grp;
                            r_lanes   <= w_issue_lanes;
                            r_mask    <= w_issue_mask;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready       = (r_state == ST_LOAD);
    assign softmax_enable = (r_state == ST_ISSUE);
    assign busy           = (r_state != ST_IDLE);
    assign done           = (r_state == ST_DONE);
    assign max_input      = r_max_input;
    assign in1            = r_lanes[0];
    assign in2            = r_lanes[1];
    assign in3            = r_lanes[2];
    assign in4            = r_lanes[3];
    assign lane_mask      = r_mask;

endmodule

// File: tb/tb_softmax_max_issue_ctrl.sv
// Directed bench for softmax_max_issue_ctrl: float (10 elems) and 16-bit
// fixed (5 elems) instances, scoreboarded per issued group.
module tb_softmax_max_issue_ctrl;

    typedef struct packed {
        logic [3:0][31:0] l;
        logic [31:0]      mx;
        logic [3:0]       mask;
    } grp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic             f_start, f_in_valid, f_in_ready, f_start_exp, f_en, f_busy, f_done;
    logic [3:0][31:0] f_l;
    logic [31:0]      f_max, f_o1, f_o2, f_o3, f_o4;
    logic [3:0]       f_mask;

    logic             x_start, x_in_valid, x_in_ready, x_start_exp, x_en, x_busy, x_done;
    logic [3:0][15:0] x_l;
    logic [15:0]      x_max, x_o1, x_o2, x_o3, x_o4;
    logic [3:0]       x_mask;

    softmax_max_issue_ctrl #(.ARITH_TYPE(0), .DATA_WIDTH(32), .E(8), .M(23), .NUM_ELEMS(10)) u_dut_f (
        .clk(clk), .reset(reset), .start(f_start), .in_valid(f_in_valid), .in_ready(f_in_ready),
        .in_lane1(f_l[0]), .in_lane2(f_l[1]), .in_lane3(f_l[2]), .in_lane4(f_l[3]),
        .start_exp(f_start_exp), .softmax_enable(f_en), .max_input(f_max),
        .in1(f_o1), .in2(f_o2), .in3(f_o3), .in4(f_o4), .lane_mask(f_mask),
        .busy(f_busy), .done(f_done));

    softmax_max_issue_ctrl #(.ARITH_TYPE(1), .DATA_WIDTH(16), .E(5), .M(10), .NUM_ELEMS(5)) u_dut_x (
        .clk(clk), .reset(reset), .start(x_start), .in_valid(x_in_valid), .in_ready(x_in_ready),
        .in_lane1(x_l[0]), .in_lane2(x_l[1]), .in_lane3(x_l[2]), .in_lane4(x_l[3]),
        .start_exp(x_start_exp), .softmax_enable(x_en), .max_input(x_max),
        .in1(x_o1), .in2(x_o2), .in3(x_o3), .in4(x_o4), .lane_mask(x_mask),
        .busy(x_busy), .done(x_done));

    int   n_vec = 0;
    int   n_err = 0;
    grp_t qf[$];
    grp_t qx[$];
    grp_t cur_f, cur_x;
    logic f_en_prev = 1'b0;
    logic x_en_prev = 1'b0;
    logic [31:0] fv [12];
    logic [15:0] xv [8];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint fkey(input logic [31:0] a);
        longint m;
        m = longint'(a[30:0]);
        return a[31] ? -m : m;
    endfunction

    task automatic expect_f();
        logic [31:0] mx;
        grp_t r;
        mx = fv[0];
        for (int i = 1; i < 10; i++)
            if (fkey(fv[i]) > fkey(mx)) mx = fv[i];
        for (int g = 0; g < 3; g++) begin
            r.mx = mx;
            r.mask = '0;
            for (int k = 0; k < 4; k++) begin
                if (4*g + k < 10) begin
                    r.l[k] = fv[4*g + k];
                    r.mask[k] = 1'b1;
                end else begin
                    r.l[k] = mx;
                end
            end
            qf.push_back(r);
        end
    endtask

    task automatic expect_x();
        logic [15:0] mx;
        grp_t r;
        mx = xv[0];
        for (int i = 1; i < 5; i++)
            if ($signed(xv[i]) > $signed(mx)) mx = xv[i];
        for (int g = 0; g < 2; g++) begin
            r.mx = 32'(mx);
            r.mask = '0;
            for (int k = 0; k < 4; k++) begin
                if (4*g + k < 5) begin
                    r.l[k] = 32'(xv[4*g + k]);
                    r.mask[k] = 1'b1;
                end else begin
                    r.l[k] = 32'(mx);
                end
            end
            qx.push_back(r);
        end
    endtask

    always @(negedge clk) begin
        if (f_en) begin
            chk("f_en_width", f_en_prev, 0);
            if (qf.size() == 0) begin
                chk("f_unexpected_issue", 1, 0);
            end else begin
                cur_f = qf.pop_front();
                chk("f_max", f_max, cur_f.mx);
                chk("f_lanes", {f_o4, f_o3, f_o2, f_o1}, cur_f.l);
                chk("f_mask", f_mask, cur_f.mask);
            end
        end
        if (x_en) begin
            chk("x_en_width", x_en_prev, 0);
            if (qx.size() == 0) begin
                chk("x_unexpected_issue", 1, 0);
            end else begin
                cur_x = qx.pop_front();
                chk("x_max", 32'(x_max), cur_x.mx);
                chk("x_lanes", {32'(x_o4), 32'(x_o3), 32'(x_o2), 32'(x_o1)}, cur_x.l);
                chk("x_mask", x_mask, cur_x.mask);
            end
        end
        f_en_prev = f_en;
        x_en_prev = x_en;
    end

    task automatic load_f(input bit bubble);
        bit acc;
        int t;
        @(posedge clk); #1 f_start = 1'b1;
        @(posedge clk); #1 f_start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            acc = 1'b0;
            t = 0;
            while (!acc && t < 20) begin
                if (bubble && (t % 2 == 0)) begin
                    f_in_valid = 1'b0;
                    for (int k = 0; k < 4; k++) f_l[k] = $urandom;
                end else begin
                    f_in_valid = 1'b1;
                    for (int k = 0; k < 4; k++) f_l[k] = fv[4*b + k];
                end
                acc = f_in_valid && f_in_ready;
                @(posedge clk); #1;
                t++;
            end
            if (!acc) chk("f_load_timeout", 0, 1);
        end
        f_in_valid = 1'b0;
        chk("f_issue_latency", f_en, 1);
    endtask

    task automatic run_f(input int ngrp, input int dly, input bit glitch);
        int t;
        for (int g = 0; g < ngrp; g++) begin
            t = 0;
            while (!f_en && t < 30) begin
                @(posedge clk); #1;
                t++;
            end
            chk("f_issue_seen", f_en, 1);
            if (glitch) f_start_exp = 1'b1;
            @(posedge clk); #1 f_start_exp = 1'b0;
            chk("f_en_after_issue", {f_en, f_done, f_busy}, 3'b001);
            for (int d = 0; d < dly; d++) begin
                chk("f_hold_a", {f_max, f_o1, f_o2, f_o3}, {cur_f.mx, cur_f.l[0], cur_f.l[1], cur_f.l[2]});
                chk("f_hold_b", {f_o4, 28'd0, f_mask, f_en}, {cur_f.l[3], 28'd0, cur_f.mask, 1'b0});
                @(posedge clk); #1;
            end
            f_start_exp = 1'b1;
            @(posedge clk); #1 f_start_exp = 1'b0;
        end
        if (ngrp == 3) begin
            chk("f_done", {f_done, f_en}, 2'b10);
            @(posedge clk); #1;
            chk("f_done_pulse", {f_done, f_busy}, 2'b00);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        f_start = 0; f_in_valid = 0; f_start_exp = 0; f_l = '0;
        x_start = 0; x_in_valid = 0; x_start_exp = 0; x_l = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("f_reset_ctl", {f_in_ready, f_en, f_busy, f_done, f_mask}, 8'd0);
        chk("f_reset_data", {f_max, f_o1, f_o2, f_o3, f_o4}, 160'd0);
        chk("x_reset_ctl", {x_in_ready, x_en, x_busy, x_done, x_mask, x_max}, 24'd0);

        // 1: mixed float vector, padding lanes carry a huge value that must be ignored
        fv = '{32'h3F800000, 32'hC0400000, 32'h40000000, 32'h3F000000,
               32'h40B00000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
               32'h40000000, 32'hC0400000, 32'h7F000000, 32'h7F000000};
        expect_f();
        load_f(1'b0);
        run_f(3, 0, 1'b0);
        chk("t1_max_const", f_max, 32'h40B00000);
        chk("t1_last_grp", {f_o3, f_o4, f_mask}, {32'h40B00000, 32'h40B00000, 4'b0011});

        // 2a: all negative, padding zeros would win if not masked
        for (int i = 0; i < 10; i++) fv[i] = 32'hC0400000;
        fv[10] = 32'h0; fv[11] = 32'h0;
        expect_f();
        load_f(1'b0);
        run_f(3, 0, 1'b0);
        chk("t2_max_const", f_max, 32'hC0400000);

        // 2b: signed zeros tie, first seen (-0) is kept
        fv = '{32'h80000000, 32'h00000000, 32'hBF800000, 32'hC0000000,
               32'h00000000, 32'h80000000, 32'hC0400000, 32'hBF800000,
               32'hC0000000, 32'h80000000, 32'h3F800000, 32'h3F800000};
        expect_f();
        load_f(1'b0);
        run_f(3, 0, 1'b0);
        chk("t2b_max_const", f_max, 32'h80000000);

        // 3: back-pressure with junk on idle cycles
        for (int i = 0; i < 12; i++)
            fv[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 135)), 23'($urandom)};
        expect_f();
        load_f(1'b1);
        run_f(3, 0, 1'b0);

        // 4: slow ack, with an ack attempt inside each ISSUE cycle
        for (int i = 0; i < 12; i++)
            fv[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 135)), 23'($urandom)};
        expect_f();
        load_f(1'b0);
        run_f(3, 5, 1'b1);

        // 5: reset during WAIT_ACK of group 2, then a fresh vector
        for (int i = 0; i < 12; i++)
            fv[i] = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 135)), 23'($urandom)};
        expect_f();
        load_f(1'b0);
        run_f(1, 0, 1'b0);
        begin
            int t = 0;
            while (!f_en && t < 30) begin
                @(posedge clk); #1;
                t++;
            end
            chk("t5_issue2_seen", f_en, 1);
        end
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        qf.delete();
        chk("t5_reset_ctl", {f_in_ready, f_en, f_busy, f_done, f_mask}, 8'd0);
        chk("t5_reset_data", {f_max, f_o1, f_o2, f_o3, f_o4}, 160'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("t5_quiet", {f_en, f_busy}, 2'b00);
        end
        fv = '{32'hC1000000, 32'h41200000, 32'h3F000000, 32'hC0000000,
               32'h40400000, 32'h41100000, 32'h00000000, 32'h41200000,
               32'hBF000000, 32'h40800000, 32'h7F000000, 32'h7F000000};
        expect_f();
        load_f(1'b0);
        run_f(3, 0, 1'b0);
        chk("t5_new_max", f_max, 32'h41200000);

        // 6: fixed point, extra start pulses held high through LOAD and first issue
        xv = '{16'hFFFB, 16'h0007, 16'h0007, 16'h8000, 16'h0003, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        expect_x();
        @(posedge clk); #1 x_start = 1'b1;
        @(posedge clk); #1;
        for (int b = 0; b < 2; b++) begin
            chk("x_ready", x_in_ready, 1);
            x_in_valid = 1'b1;
            for (int k = 0; k < 4; k++) x_l[k] = xv[4*b + k];
            @(posedge clk); #1;
        end
        x_in_valid = 1'b0;
        chk("x_issue_latency", x_en, 1);
        for (int g = 0; g < 2; g++) begin
            int t = 0;
            while (!x_en && t < 30) begin
                @(posedge clk); #1;
                t++;
            end
            chk("x_issue_seen", x_en, 1);
            @(posedge clk); #1;
            x_start = 1'b0;
            x_start_exp = 1'b1;
            @(posedge clk); #1 x_start_exp = 1'b0;
        end
        chk("x_done", x_done, 1);
        chk("x_max_const", x_max, 16'h0007);
        @(posedge clk); #1;
        chk("x_idle", {x_busy, x_done, x_en}, 3'b000);
        chk("f_queue_empty", qf.size(), 0);
        chk("x_queue_empty", qx.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
